// File: rtl/sm3_pad_pkg.sv
// SM3 padder shared types: FSM states, pad marker word and block index constants.
// Latency: none (package only).
// Backpressure: not applicable.
package sm3_pad_pkg;

  localparam int INPT_DW     = 32;
  localparam int BLK_WRD_NUM = 16;
  localparam int BYTE_CNT_DW = 61;
  localparam int IDX_W       = $clog2(BLK_WRD_NUM);

  localparam logic [31:0]      PAD_MARK_WRD = 32'h8000_0000;
  localparam logic [IDX_W-1:0] LEN_HI_IDX   = 4'd14;
  localparam logic [IDX_W-1:0] LEN_LO_IDX   = 4'd15;
  // Last index at which zero fill may still be emitted before the length words.
  localparam logic [IDX_W-1:0] PRE_LEN_IDX  = LEN_HI_IDX - 4'd1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    PAD_80   = 3'd2,
    PAD_ZERO = 3'd3,
    LEN_HI   = 3'd4,
    LEN_LO   = 3'd5
  } pad_st_e;

endpackage

// File: rtl/sm3_pad_lst_wrd_fmt.sv
// Formats the last message word: keeps valid bytes, inserts 0x80 at the first invalid byte.
// Latency: combinational.
// Backpressure: none; pure function of the inputs.
module sm3_pad_lst_wrd_fmt (
  input  logic [31:0] dat_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] wrd_o,
  output logic [2:0]  byte_num_o,
  output logic        full_o
);

  // Contiguous partial masks carry the marker; full or non-contiguous masks pass the word through.
  always_comb begin
    wrd_o      = dat_i;
    byte_num_o = 3'd4;
    full_o     = 1'b1;
    case (mask_i)
      4'b1110: begin wrd_o = {dat_i[31:8], 8'h80};      byte_num_o = 3'd3; full_o = 1'b0; end
      4'b1100: begin wrd_o = {dat_i[31:16], 16'h8000};  byte_num_o = 3'd2; full_o = 1'b0; end
      4'b1000: begin wrd_o = {dat_i[31:24], 24'h800000}; byte_num_o = 3'd1; full_o = 1'b0; end
      4'b0000: begin wrd_o = 32'h8000_0000;             byte_num_o = 3'd0; full_o = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sm3_msg_pad_rcvr.sv
// SM3 message padder: passes message words, appends 0x80, zero fill and 64-bit bit length.
// Latency: 1 cycle from accepted input (or generated pad word) to pad_otpt_*.
// Backpressure: output register holds while vld & ~ena; msg_inpt_rdy low during padding.
module sm3_msg_pad_rcvr
  import sm3_pad_pkg::*;
#(
  parameter int INPT_DW_P     = INPT_DW,
  parameter int BYTE_CNT_DW_P = BYTE_CNT_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INPT_DW_P-1:0] msg_inpt_d,
  input  logic [3:0]           msg_inpt_vld_byte,
  input  logic                 msg_inpt_vld,
  input  logic                 msg_inpt_lst,
  output logic                 msg_inpt_rdy,
  output logic [INPT_DW_P-1:0] pad_otpt_d,
  output logic                 pad_otpt_vld,
  output logic                 pad_otpt_blk_end,
  output logic                 pad_otpt_msg_end,
  input  logic                 pad_otpt_ena
);

  pad_st_e                  state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [BYTE_CNT_DW_P-1:0] byte_cnt_q, byte_cnt_d;
  logic [INPT_DW_P-1:0]     pad_d_q, wrd_d;
  logic                     pad_vld_q, blk_end_q, msg_end_q;
  logic                     wrd_vld;
  logic                     load, in_acc;
  logic [63:0]              bit_len;
  logic [31:0]              fmt_wrd;
  logic [2:0]               fmt_byte_num;
  logic                     fmt_full;
  logic [2:0]               add_bytes;

  sm3_pad_lst_wrd_fmt u_fmt (
    .dat_i      (msg_inpt_d),
    .mask_i     (msg_inpt_vld_byte),
    .wrd_o      (fmt_wrd),
    .byte_num_o (fmt_byte_num),
    .full_o     (fmt_full)
  );

  assign load         = ~pad_vld_q | pad_otpt_ena;
  assign msg_inpt_rdy = ~rst & load & ((state_q == IDLE) | (state_q == DATA));
  assign in_acc       = msg_inpt_vld & msg_inpt_rdy;
  assign bit_len      = {byte_cnt_q, 3'b000};
  assign add_bytes    = msg_inpt_lst ? fmt_byte_num : 3'd4;

  assign pad_otpt_d       = pad_d_q;
  assign pad_otpt_vld     = pad_vld_q;
  assign pad_otpt_blk_end = blk_end_q;
  assign pad_otpt_msg_end = msg_end_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: marker-bearing or zero words emitted at index 13 jump straight to the length words.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DATA: begin
        if (in_acc) begin
          if (!msg_inpt_lst)         state_d = DATA;
          else if (fmt_full)         state_d = PAD_80;
          else if (idx_q == PRE_LEN_IDX) state_d = LEN_HI;
          else                       state_d = PAD_ZERO;
        end
      end
      PAD_80, PAD_ZERO: if (load) state_d = (idx_q == PRE_LEN_IDX) ? LEN_HI : PAD_ZERO;
      LEN_HI:           if (load) state_d = LEN_LO;
      LEN_LO:           if (load) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Output word selection and byte count update for the next register load.
  always_comb begin
    wrd_vld    = 1'b0;
    wrd_d      = '0;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      IDLE, DATA: begin
        if (in_acc) begin
          wrd_vld    = 1'b1;
          wrd_d      = msg_inpt_lst ? fmt_wrd : msg_inpt_d;
          byte_cnt_d = ((state_q == IDLE) ? '0 : byte_cnt_q)
                       + {{(BYTE_CNT_DW_P-3){1'b0}}, add_bytes};
        end
      end
      PAD_80:   begin wrd_vld = load; wrd_d = PAD_MARK_WRD;   end
      PAD_ZERO: begin wrd_vld = load; wrd_d = '0;             end
      LEN_HI:   begin wrd_vld = load; wrd_d = bit_len[63:32]; end
      LEN_LO:   begin wrd_vld = load; wrd_d = bit_len[31:0];  end
      default:  ;
    endcase
  end

  // Output register, word index and byte counter; everything holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      byte_cnt_q <= '0;
      pad_d_q    <= '0;
      pad_vld_q  <= 1'b0;
      blk_end_q  <= 1'b0;
      msg_end_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      if (load) begin
        pad_vld_q <= wrd_vld;
        blk_end_q <= wrd_vld & (idx_q == LEN_LO_IDX);
        msg_end_q <= wrd_vld & (state_q == LEN_LO);
        if (wrd_vld) begin
          pad_d_q <= wrd_d;
          idx_q   <= idx_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm3_msg_pad_rcvr.sv
// Directed bench for the SM3 padder: table of messages with hand-computed padded blocks.
// Latency: checks words as they transfer on pad_otpt_vld & pad_otpt_ena.
// Backpressure: optional random ena/vld gaps, with stability checks while stalled.
module tb_sm3_msg_pad_rcvr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] msg_inpt_d;
  logic [3:0]  msg_inpt_vld_byte;
  logic        msg_inpt_vld;
  logic        msg_inpt_lst;
  logic        msg_inpt_rdy;
  logic [31:0] pad_otpt_d;
  logic        pad_otpt_vld;
  logic        pad_otpt_blk_end;
  logic        pad_otpt_msg_end;
  logic        pad_otpt_ena;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm3_msg_pad_rcvr dut (
    .clk               (clk),
    .rst               (rst),
    .msg_inpt_d        (msg_inpt_d),
    .msg_inpt_vld_byte (msg_inpt_vld_byte),
    .msg_inpt_vld      (msg_inpt_vld),
    .msg_inpt_lst      (msg_inpt_lst),
    .msg_inpt_rdy      (msg_inpt_rdy),
    .pad_otpt_d        (pad_otpt_d),
    .pad_otpt_vld      (pad_otpt_vld),
    .pad_otpt_blk_end  (pad_otpt_blk_end),
    .pad_otpt_msg_end  (pad_otpt_msg_end),
    .pad_otpt_ena      (pad_otpt_ena)
  );

  // One message: n_wrd input words (all 'dat' except the last, 'lst_dat' with 'mask'),
  // expected output length, position/value of the 0x80-carrying word and low length word.
  typedef struct {
    int          n_wrd;
    logic [31:0] dat;
    logic [31:0] lst_dat;
    logic [3:0]  mask;
    int          exp_n;
    int          mark_pos;
    logic [31:0] mark_wrd;
    logic [31:0] len_lo;
    bit          rnd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected {msg_end, blk_end, d} for output word k of message v.
  function automatic logic [33:0] exp_word(input vec_t v, input int k);
    logic [31:0] d;
    if (k == v.exp_n - 1)      d = v.len_lo;
    else if (k == v.exp_n - 2) d = 32'h0;
    else if (k == v.mark_pos)  d = v.mark_wrd;
    else if (k < v.n_wrd)      d = (k == v.n_wrd - 1) ? v.lst_dat : v.dat;
    else                       d = 32'h0;
    return {(k == v.exp_n - 1), ((k % 16) == 15), d};
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int          sent = 0;
    int          rec = 0;
    int          cyc = 0;
    int          rdy_bad = 0;
    bit          lst_acc = 0;
    bit          hold = 0;
    logic        rdy_at_end = 1'b0;
    logic [34:0] held = '0;
    while (rec < v.exp_n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      pad_otpt_ena = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sent < v.n_wrd && (!v.rnd || $urandom_range(0, 3) != 0)) begin
        msg_inpt_vld      = 1'b1;
        msg_inpt_lst      = (sent == v.n_wrd - 1);
        msg_inpt_d        = msg_inpt_lst ? v.lst_dat : v.dat;
        msg_inpt_vld_byte = msg_inpt_lst ? v.mask : 4'b0000;
      end else begin
        msg_inpt_vld = 1'b0;
        msg_inpt_lst = 1'b0;
      end
      #1;
      if (hold)
        chk($sformatf("v%0d stable", id),
            {29'd0, pad_otpt_vld, pad_otpt_msg_end, pad_otpt_blk_end, pad_otpt_d}, {29'd0, held});
      if (lst_acc && msg_inpt_rdy && !(pad_otpt_vld && pad_otpt_ena && rec == v.exp_n - 1))
        rdy_bad++;
      hold = pad_otpt_vld & ~pad_otpt_ena;
      held = {pad_otpt_vld, pad_otpt_msg_end, pad_otpt_blk_end, pad_otpt_d};
      if (pad_otpt_vld && pad_otpt_ena) begin
        chk($sformatf("v%0d word%0d", id, rec),
            {30'd0, pad_otpt_msg_end, pad_otpt_blk_end, pad_otpt_d}, {30'd0, exp_word(v, rec)});
        if (rec == v.exp_n - 1) rdy_at_end = msg_inpt_rdy;
        rec++;
      end
      if (msg_inpt_vld && msg_inpt_rdy) begin
        if (msg_inpt_lst) lst_acc = 1'b1;
        sent++;
      end
    end
    @(negedge clk);
    msg_inpt_vld = 1'b0;
    msg_inpt_lst = 1'b0;
    pad_otpt_ena = 1'b1;
    chk($sformatf("v%0d word count", id), 64'(rec), 64'(v.exp_n));
    chk($sformatf("v%0d rdy during pad", id), 64'(rdy_bad), 64'd0);
    chk($sformatf("v%0d rdy at len_lo xfer", id), {63'd0, rdy_at_end}, 64'd1);
  endtask

  initial begin
    //          n   dat            lst_dat        mask     exp mark mark_wrd       len_lo        rnd
    vecs[0]  = '{1,  32'h0,        32'h6162_6300, 4'b1110, 16, 0,  32'h6162_6380, 32'h0000_0018, 1'b0};
    vecs[1]  = '{1,  32'h0,        32'h1234_5678, 4'b0000, 16, 0,  32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{14, 32'h0102_0304, 32'h0102_0300, 4'b1110, 16, 13, 32'h0102_0380, 32'h0000_01B8, 1'b0};
    vecs[3]  = '{14, 32'h0102_0304, 32'h0102_0304, 4'b1111, 32, 14, 32'h8000_0000, 32'h0000_01C0, 1'b0};
    vecs[4]  = '{16, 32'h0102_0304, 32'h0102_0304, 4'b1111, 32, 16, 32'h8000_0000, 32'h0000_0200, 1'b0};
    vecs[5]  = '{13, 32'hA5A5_5A5A, 32'h1111_2222, 4'b1111, 16, 13, 32'h8000_0000, 32'h0000_01A0, 1'b0};
    vecs[6]  = '{1,  32'h0,        32'hAABB_CCDD, 4'b1000, 16, 0,  32'hAA80_0000, 32'h0000_0008, 1'b0};
    vecs[7]  = '{2,  32'hDEAD_BEEF, 32'hAABB_CCDD, 4'b1100, 16, 1,  32'hAABB_8000, 32'h0000_0030, 1'b0};
    vecs[8]  = '{1,  32'h0,        32'hCAFE_F00D, 4'b1010, 16, 1,  32'h8000_0000, 32'h0000_0020, 1'b0};
    vecs[9]  = '{1,  32'h0,        32'h6162_6300, 4'b1110, 16, 0,  32'h6162_6380, 32'h0000_0018, 1'b1};
    vecs[10] = '{16, 32'h0102_0304, 32'h0102_0304, 4'b1111, 32, 16, 32'h8000_0000, 32'h0000_0200, 1'b1};

    rst               = 1'b1;
    msg_inpt_d        = '0;
    msg_inpt_vld_byte = '0;
    msg_inpt_vld      = 1'b0;
    msg_inpt_lst      = 1'b0;
    pad_otpt_ena      = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset vld", {63'd0, pad_otpt_vld}, 64'd0);
    chk("reset d", {32'd0, pad_otpt_d}, 64'd0);
    chk("reset blk/msg end", {62'd0, pad_otpt_blk_end, pad_otpt_msg_end}, 64'd0);
    chk("reset rdy", {63'd0, msg_inpt_rdy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle rdy", {63'd0, msg_inpt_rdy}, 64'd1);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a block, then 'abc' must come out as a clean block.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      msg_inpt_vld      = 1'b1;
      msg_inpt_lst      = 1'b0;
      msg_inpt_d        = 32'h7777_0000 + 32'(i);
      msg_inpt_vld_byte = 4'b1111;
    end
    @(negedge clk);
    msg_inpt_vld = 1'b0;
    rst          = 1'b1;
    #1;
    chk("rst mid rdy", {63'd0, msg_inpt_rdy}, 64'd0);
    @(negedge clk);
    #1;
    chk("rst mid vld", {63'd0, pad_otpt_vld}, 64'd0);
    chk("rst mid flags", {62'd0, pad_otpt_blk_end, pad_otpt_msg_end}, 64'd0);
    rst = 1'b0;
    run_vec(11, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
